// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX operand stage: ALU opcodes, forwarding selects, ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  // Default datapath and register-index widths. The ID/EX struct below is
  // laid out with these widths, so the top-level parameters should match them.
  localparam int XLEN = 32;
  localparam int REGW = 5;

  // ALU opcodes carried through ID/EX. Codes 1011-1111 are undefined. They
  // still pass through unchanged, because this stage never interprets the opcode.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1010
  } alu_op_t;

  // Operand source select. 11 never occurs and is treated as FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Every field held in the ID/EX pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    alu_op_t         alu_ctrl;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
    logic            valid;
  } id_ex_t;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select plus 3:1 operand mux for one EX source register.
// Latency: purely combinational, with no added cycle.
// Backpressure: none. It re-evaluates every cycle, including while ID/EX is stalled.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  rs,
  input  logic [DATA_W-1:0] reg_dat,
  input  logic [REG_W-1:0]  rd_m,
  input  logic              reg_write_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [REG_W-1:0]  rd_w,
  input  logic              reg_write_w,
  input  logic [DATA_W-1:0] result_w,
  output fwd_sel_t          sel,
  output logic [DATA_W-1:0] fwd
);

  // Pick the youngest in-flight producer of rs. MEM is newer than WB, so it wins. x0 is never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

  // Operand mux. The unreachable 11 code falls back to register-file data.
  always_comb begin
    case (sel)
      FWD_MEM: fwd = alu_result_m;
      FWD_WB:  fwd = result_w;
      default: fwd = reg_dat;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding, driving the ALU operands and opcode.
// Latency: decode fields appear one cycle after capture; forwarded operands are combinational from E and M/W.
// Backpressure: StallE holds the register, FlushE loads a bubble (flush wins), and LoadUseHazard goes to the hazard unit.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_W  = REGW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] ImmExtD,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  RdD,
  input  logic [3:0]        ALUControlD,
  input  logic              ALUSrcAD,
  input  logic              ALUSrcBD,
  input  logic              RegWriteD,
  input  logic              MemReadD,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [REG_W-1:0]  RdM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [REG_W-1:0]  RdW,
  input  logic              RegWriteW,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] SrcBE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [3:0]        ALUControlE,
  output logic [DATA_W-1:0] PCE,
  output logic [REG_W-1:0]  RdE,
  output logic              RegWriteE,
  output logic              MemReadE,
  output logic              ValidE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              LoadUseHazard
);

  id_ex_t            d_fields;
  id_ex_t            e_q;
  fwd_sel_t          fwd_a_sel;
  fwd_sel_t          fwd_b_sel;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Gather the decode-stage fields into the register layout.
  always_comb begin
    d_fields           = '0;
    d_fields.pc        = PCD;
    d_fields.imm       = ImmExtD;
    d_fields.rd1       = RD1D;
    d_fields.rd2       = RD2D;
    d_fields.rs1       = Rs1D;
    d_fields.rs2       = Rs2D;
    d_fields.rd        = RdD;
    d_fields.alu_ctrl  = alu_op_t'(ALUControlD);
    d_fields.alu_src_a = ALUSrcAD;
    d_fields.alu_src_b = ALUSrcBD;
    d_fields.reg_write = RegWriteD;
    d_fields.mem_read  = MemReadD;
    d_fields.valid     = ValidD;
  end

  // ID/EX register. Priority is reset, then flush (bubble, which beats stall), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else if (!StallE) begin
      e_q <= d_fields;
    end
  end

  // rs1 path. Forwarding keeps tracking M/W while the register is held.
  forward_unit #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_a (
    .rs           (e_q.rs1),
    .reg_dat      (e_q.rd1),
    .rd_m         (RdM),
    .reg_write_m  (RegWriteM),
    .alu_result_m (ALUResultM),
    .rd_w         (RdW),
    .reg_write_w  (RegWriteW),
    .result_w     (ResultW),
    .sel          (fwd_a_sel),
    .fwd          (fwd_a)
  );

  // rs2 path. This also supplies the store data.
  forward_unit #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_b (
    .rs           (e_q.rs2),
    .reg_dat      (e_q.rd2),
    .rd_m         (RdM),
    .reg_write_m  (RegWriteM),
    .alu_result_m (ALUResultM),
    .rd_w         (RdW),
    .reg_write_w  (RegWriteW),
    .result_w     (ResultW),
    .sel          (fwd_b_sel),
    .fwd          (fwd_b)
  );

  // ALU operand selection. Store data always takes the forwarded rs2, never the immediate.
  always_comb begin
    SrcAE      = e_q.alu_src_a ? e_q.pc  : fwd_a;
    SrcBE      = e_q.alu_src_b ? e_q.imm : fwd_b;
    WriteDataE = fwd_b;
  end

  // A load in EX whose destination feeds the instruction in decode cannot be forwarded in time.
  always_comb begin
    LoadUseHazard = e_q.valid && e_q.mem_read && (e_q.rd != '0) &&
                    ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));
  end

  // Registered control and PC outputs, plus the forwarding selects for the hazard and debug logic.
  always_comb begin
    ALUControlE = e_q.alu_ctrl;
    PCE         = e_q.pc;
    RdE         = e_q.rd;
    RegWriteE   = e_q.reg_write;
    MemReadE    = e_q.mem_read;
    ValidE      = e_q.valid;
    ForwardAE   = fwd_a_sel;
    ForwardBE   = fwd_b_sel;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: the model captures decode inputs on each rising edge, and outputs are compared 1 time unit after the inputs settle.
// Backpressure: StallE and FlushE are driven directly, with flush taking precedence over stall.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [3:0]  ALUControlD;
  logic        ALUSrcAD, ALUSrcBD, RegWriteD, MemReadD, ValidD;
  logic [31:0] ALUResultM, ResultW;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RdE;
  logic        RegWriteE, MemReadE, ValidE, LoadUseHazard;
  logic [1:0]  ForwardAE, ForwardBE;

  int vectors = 0;
  int miscompares = 0;

  // Model of the EX-side register contents.
  logic [31:0] m_pc, m_imm, m_rd1, m_rd2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic        m_sa, m_sb, m_rw, m_mr, m_v;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD),
    .MemReadD(MemReadD), .ValidD(ValidD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .ALUControlE(ALUControlE), .PCE(PCE), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .ValidE(ValidE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LoadUseHazard(LoadUseHazard)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Select rule: a MEM-stage writer matching rs wins, then a WB-stage writer; register x0 never matches.
  function automatic logic [1:0] exp_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs, input logic [31:0] regv);
    logic [1:0] s;
    s = exp_sel(rs);
    if (s == 2'b10) return ALUResultM;
    if (s == 2'b01) return ResultW;
    return regv;
  endfunction

  // Advance the model by one rising edge, using the inputs as they stand at that edge.
  task automatic model_edge();
    if (rst || FlushE) begin
      {m_pc, m_imm, m_rd1, m_rd2} = '0;
      {m_rs1, m_rs2, m_rd, m_alu} = '0;
      {m_sa, m_sb, m_rw, m_mr, m_v} = '0;
    end else if (!StallE) begin
      m_pc = PCD; m_imm = ImmExtD; m_rd1 = RD1D; m_rd2 = RD2D;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD; m_alu = ALUControlD;
      m_sa = ALUSrcAD; m_sb = ALUSrcBD; m_rw = RegWriteD; m_mr = MemReadD; m_v = ValidD;
    end
  endtask

  // Check every output against the model.
  task automatic model_check();
    logic [31:0] fa, fb;
    fa = exp_val(m_rs1, m_rd1);
    fb = exp_val(m_rs2, m_rd2);
    chk("SrcAE", SrcAE, m_sa ? m_pc : fa);
    chk("SrcBE", SrcBE, m_sb ? m_imm : fb);
    chk("WriteDataE", WriteDataE, fb);
    chk("ForwardAE", {30'd0, ForwardAE}, {30'd0, exp_sel(m_rs1)});
    chk("ForwardBE", {30'd0, ForwardBE}, {30'd0, exp_sel(m_rs2)});
    chk("ALUControlE", {28'd0, ALUControlE}, {28'd0, m_alu});
    chk("PCE", PCE, m_pc);
    chk("RdE", {27'd0, RdE}, {27'd0, m_rd});
    chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, m_rw});
    chk("MemReadE", {31'd0, MemReadE}, {31'd0, m_mr});
    chk("ValidE", {31'd0, ValidE}, {31'd0, m_v});
    chk("LoadUseHazard", {31'd0, LoadUseHazard},
        {31'd0, m_v && m_mr && m_rd != 5'd0 && (m_rd == Rs1D || m_rd == Rs2D)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic rand_d(input logic [4:0] idx_max);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom_range(0, idx_max)); Rs2D = 5'($urandom_range(0, idx_max));
    RdD = 5'($urandom_range(0, idx_max));
    ALUControlD = 4'($urandom); ALUSrcAD = 1'($urandom); ALUSrcBD = 1'($urandom);
    RegWriteD = 1'($urandom); MemReadD = 1'($urandom); ValidD = 1'($urandom);
  endtask

  task automatic quiet_mw();
    ALUResultM = 32'h0; RdM = 5'd0; RegWriteM = 1'b0;
    ResultW = 32'h0; RdW = 5'd0; RegWriteW = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc;
    // Reset with nonzero decode inputs. Everything on the E side must read as zero.
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    quiet_mw();
    rand_d(5'd31);
    PCD = 32'h0000_1234; RdD = 5'd9; ValidD = 1'b1; RegWriteD = 1'b1;
    tick(); tick();
    settle();
    chk("rst_PCE", PCE, 32'h0);
    chk("rst_ValidE", {31'd0, ValidE}, 32'h0);
    chk("rst_RdE", {27'd0, RdE}, 32'h0);
    chk("rst_SrcAE", SrcAE, 32'h0);
    rst = 1'b0;
    tick();
    settle();
    chk("load_PCE", PCE, 32'h0000_1234);
    chk("load_RdE", {27'd0, RdE}, 32'd9);
    chk("load_ValidE", {31'd0, ValidE}, 32'd1);

    // Forward from MEM onto rs1.
    rand_d(5'd31); Rs1D = 5'd5; RD1D = 32'h1; ALUSrcAD = 1'b0;
    tick();
    RegWriteM = 1'b1; RdM = 5'd5; ALUResultM = 32'hAA;
    settle();
    chk("memfwd_ForwardAE", {30'd0, ForwardAE}, 32'd2);
    chk("memfwd_SrcAE", SrcAE, 32'hAA);

    // MEM and WB both write rs2, and MEM must win.
    quiet_mw();
    rand_d(5'd31); Rs2D = 5'd7; ALUSrcBD = 1'b0;
    tick();
    RegWriteM = 1'b1; RdM = 5'd7; ALUResultM = 32'h11;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h22;
    settle();
    chk("prio_ForwardBE", {30'd0, ForwardBE}, 32'd2);
    chk("prio_WriteDataE", WriteDataE, 32'h11);

    // x0 is never forwarded.
    quiet_mw();
    rand_d(5'd31); Rs1D = 5'd0; RD1D = 32'h0; ALUSrcAD = 1'b0;
    tick();
    RegWriteM = 1'b1; RdM = 5'd0; ALUResultM = 32'h55;
    settle();
    chk("x0_ForwardAE", {30'd0, ForwardAE}, 32'd0);
    chk("x0_SrcAE", SrcAE, 32'h0);

    // Load-use hazard, then a flush turns the instruction in EX into a bubble.
    quiet_mw();
    rand_d(5'd31); MemReadD = 1'b1; RdD = 5'd3; ValidD = 1'b1; RegWriteD = 1'b1;
    tick();
    Rs1D = 5'd9; Rs2D = 5'd3;
    settle();
    chk("lu_LoadUseHazard", {31'd0, LoadUseHazard}, 32'd1);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    settle();
    chk("lu_flush_ValidE", {31'd0, ValidE}, 32'd0);
    chk("lu_flush_RegWriteE", {31'd0, RegWriteE}, 32'd0);

    // Hold for 3 cycles while the decode inputs keep changing.
    rand_d(5'd31); PCD = 32'hCAFE_0000;
    tick();
    settle();
    held_pc = PCE;
    chk("stall_pre_PCE", PCE, 32'hCAFE_0000);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d(5'd31);
      tick();
      settle();
      chk("stall_hold_PCE", PCE, held_pc);
    end
    // Stall and flush together must produce a bubble.
    FlushE = 1'b1; rand_d(5'd31); ValidD = 1'b1;
    tick();
    StallE = 1'b0; FlushE = 1'b0;
    settle();
    chk("stallflush_ValidE", {31'd0, ValidE}, 32'd0);
    chk("stallflush_PCE", PCE, 32'h0);

    // Randomized traffic. A small register-index range makes forwarding and hazard matches frequent.
    for (int n = 0; n < 2000; n++) begin
      rand_d(5'd7);
      rst        = ($urandom_range(0, 31) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      StallE     = ($urandom_range(0, 3) == 0);
      ALUResultM = $urandom; ResultW = $urandom;
      RdM = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      settle();
      tick();
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
